// File: rtl/i3c_target_sdr_rx.sv
// i3c_target_sdr_rx
// Bus-side receive engine of an I3C target in SDR mode. SCL/SDA are
// oversampled on i_clk; START, repeated START and STOP are detected. The
// engine shifts in the address header, ACKs a matching or broadcast write
// header, and then receives data bytes with T-bit (odd parity) checking.
//
// Ports:
//   i_clk         system clock, at least 8x SCL
//   i_rst_n       synchronous active-low reset
//   i_target_en   block enable; low forces IDLE and releases SDA
//   i_ack_en      allow ACK of a matching header
//   i_scl, i_sda  raw asynchronous bus pins
//   o_sda_oe      SDA pull-low enable (ACK only)
//   o_start       1-cycle pulse on START or Sr
//   o_stop        1-cycle pulse on STOP
//   o_busy        high from START to STOP
//   o_addr_match  header ACKed; held until next START/Sr/STOP
//   o_rnw         RnW bit of the last ACKed header
//   o_rd_req      1-cycle pulse when a read header is ACKed
//   o_rx_valid    1-cycle pulse when a data byte completes
//   o_rx_data     last received byte
//   o_parity_err  pulse with o_rx_valid when the T-bit is wrong
module i3c_target_sdr_rx #(
  parameter logic [6:0] STATIC_ADDR = 7'h50,
  parameter logic [6:0] BCAST_ADDR  = 7'h7E
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_target_en,
  input  logic       i_ack_en,
  input  logic       i_scl,
  input  logic       i_sda,
  output logic       o_sda_oe,
  output logic       o_start,
  output logic       o_stop,
  output logic       o_busy,
  output logic       o_addr_match,
  output logic       o_rnw,
  output logic       o_rd_req,
  output logic       o_rx_valid,
  output logic [7:0] o_rx_data,
  output logic       o_parity_err
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, DATA, TBIT, WAIT_STOP
  } state_t;

  function automatic logic header_ack(input logic [7:0] hdr, input logic ack_en);
    logic match;
    match = (hdr[7:1] == STATIC_ADDR) || ((hdr[7:1] == BCAST_ADDR) && !hdr[0]);
    return match && ack_en;
  endfunction

  // The 9-bit total {byte, T} must carry odd parity.
  function automatic logic tbit_err(input logic [7:0] data, input logic t);
    return t != ~^data;
  endfunction

  // Stage p0/p1: two-flop synchronizer; p2: previous value of p1
  logic scl_p0, scl_p1, scl_p2;
  logic sda_p0, sda_p1, sda_p2;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      scl_p0 <= 1'b1; scl_p1 <= 1'b1; scl_p2 <= 1'b1;
      sda_p0 <= 1'b1; sda_p1 <= 1'b1; sda_p2 <= 1'b1;
    end else begin
      scl_p0 <= i_scl;  scl_p1 <= scl_p0; scl_p2 <= scl_p1;
      sda_p0 <= i_sda;  sda_p1 <= sda_p0; sda_p2 <= sda_p1;
    end
  end

  // SCL must be high in both samples for an SDA edge to count as START or
  // STOP; an SDA edge coinciding with an SCL edge is a plain data change.
  logic scl_rise_c, scl_fall_c, start_c, stop_c, scl_hold_hi;
  assign scl_rise_c  = scl_p1 & ~scl_p2;
  assign scl_fall_c  = ~scl_p1 & scl_p2;
  assign scl_hold_hi = scl_p1 & scl_p2;
  assign start_c     = ~sda_p1 & sda_p2 & scl_hold_hi;
  assign stop_c      = sda_p1 & ~sda_p2 & scl_hold_hi;

  // Stage p3: registered bus events
  logic scl_rise_p3, scl_fall_p3, start_p3, stop_p3, sda_p3;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      scl_rise_p3 <= 1'b0;
      scl_fall_p3 <= 1'b0;
      start_p3    <= 1'b0;
      stop_p3     <= 1'b0;
      sda_p3      <= 1'b1;
    end else begin
      scl_rise_p3 <= scl_rise_c;
      scl_fall_p3 <= scl_fall_c;
      start_p3    <= start_c;
      stop_p3     <= stop_c;
      sda_p3      <= sda_p1;
    end
  end

  // Stage p4: protocol FSM and registered outputs
  state_t     state, state_nx;
  logic [2:0] bit_cnt, bit_cnt_nx;
  logic [7:0] shift, shift_nx;
  logic       ack_q, ack_q_nx;
  logic       ack_phase, ack_phase_nx;
  logic       sda_oe_nx, start_nx, stop_nx, busy_nx, addr_match_nx, rnw_nx;
  logic       rd_req_nx, rx_valid_nx, parity_err_nx;
  logic [7:0] rx_data_nx;
  logic [7:0] shift_in;

  assign shift_in = {shift[6:0], sda_p3};

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      bit_cnt      <= 3'd0;
      shift        <= 8'h00;
      ack_q        <= 1'b0;
      ack_phase    <= 1'b0;
      o_sda_oe     <= 1'b0;
      o_start      <= 1'b0;
      o_stop       <= 1'b0;
      o_busy       <= 1'b0;
      o_addr_match <= 1'b0;
      o_rnw        <= 1'b0;
      o_rd_req     <= 1'b0;
      o_rx_valid   <= 1'b0;
      o_rx_data    <= 8'h00;
      o_parity_err <= 1'b0;
    end else begin
      state        <= state_nx;
      bit_cnt      <= bit_cnt_nx;
      shift        <= shift_nx;
      ack_q        <= ack_q_nx;
      ack_phase    <= ack_phase_nx;
      o_sda_oe     <= sda_oe_nx;
      o_start      <= start_nx;
      o_stop       <= stop_nx;
      o_busy       <= busy_nx;
      o_addr_match <= addr_match_nx;
      o_rnw        <= rnw_nx;
      o_rd_req     <= rd_req_nx;
      o_rx_valid   <= rx_valid_nx;
      o_rx_data    <= rx_data_nx;
      o_parity_err <= parity_err_nx;
    end
  end

  always_comb begin
    state_nx      = state;
    bit_cnt_nx    = bit_cnt;
    shift_nx      = shift;
    ack_q_nx      = ack_q;
    ack_phase_nx  = ack_phase;
    sda_oe_nx     = o_sda_oe;
    start_nx      = 1'b0;
    stop_nx       = 1'b0;
    busy_nx       = o_busy;
    addr_match_nx = o_addr_match;
    rnw_nx        = o_rnw;
    rd_req_nx     = 1'b0;
    rx_valid_nx   = 1'b0;
    rx_data_nx    = o_rx_data;
    parity_err_nx = 1'b0;

    if (!i_target_en || stop_p3) begin
      // Disable behaves like STOP, minus the o_stop pulse.
      state_nx      = IDLE;
      busy_nx       = 1'b0;
      sda_oe_nx     = 1'b0;
      addr_match_nx = 1'b0;
      bit_cnt_nx    = 3'd0;
      ack_phase_nx  = 1'b0;
      stop_nx       = i_target_en;
    end else if (start_p3) begin
      state_nx      = ADDR;
      start_nx      = 1'b1;
      busy_nx       = 1'b1;
      sda_oe_nx     = 1'b0;
      addr_match_nx = 1'b0;
      rnw_nx        = 1'b0;
      bit_cnt_nx    = 3'd0;
      shift_nx      = 8'h00;
      ack_phase_nx  = 1'b0;
    end else begin
      case (state)
        ADDR: begin
          if (scl_rise_p3) begin
            shift_nx   = shift_in;
            bit_cnt_nx = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
              state_nx = ADDR_ACK;
              ack_q_nx = header_ack(shift_in, i_ack_en);
            end
          end
        end
        ADDR_ACK: begin
          // First fall opens the ACK slot, second fall closes it.
          // shift[0] still holds the header RnW bit here.
          if (scl_fall_p3) begin
            if (!ack_phase) begin
              ack_phase_nx = 1'b1;
              sda_oe_nx    = ack_q;
              if (ack_q) begin
                addr_match_nx = 1'b1;
                rnw_nx        = shift[0];
                rd_req_nx     = shift[0];
              end
            end else begin
              ack_phase_nx = 1'b0;
              sda_oe_nx    = 1'b0;
              state_nx     = (ack_q && !shift[0]) ? DATA : WAIT_STOP;
            end
          end
        end
        DATA: begin
          if (scl_rise_p3) begin
            shift_nx   = shift_in;
            bit_cnt_nx = bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state_nx = TBIT;
          end
        end
        TBIT: begin
          if (scl_rise_p3) begin
            rx_valid_nx   = 1'b1;
            rx_data_nx    = shift;
            parity_err_nx = tbit_err(shift, sda_p3);
            state_nx      = tbit_err(shift, sda_p3) ? WAIT_STOP : DATA;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_i3c_target_sdr_rx.sv
// Testbench for i3c_target_sdr_rx: drives SDR frames on a wired-AND SDA
// and compares DUT activity with a transaction-level model of the target.
module tb_i3c_target_sdr_rx;

  localparam int H = 4;  // clocks per quarter SCL period

  logic       clk = 1'b0;
  logic       rst_n, target_en, ack_en, scl, sda_drv, sda_bus;
  logic       sda_oe, start, stop, busy, addr_match, rnw, rd_req;
  logic       rx_valid, parity_err;
  logic [7:0] rx_data;

  always #5 clk = ~clk;

  assign sda_bus = sda_drv & ~sda_oe;

  i3c_target_sdr_rx dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_target_en(target_en), .i_ack_en(ack_en),
    .i_scl(scl), .i_sda(sda_bus), .o_sda_oe(sda_oe), .o_start(start),
    .o_stop(stop), .o_busy(busy), .o_addr_match(addr_match), .o_rnw(rnw),
    .o_rd_req(rd_req), .o_rx_valid(rx_valid), .o_rx_data(rx_data),
    .o_parity_err(parity_err)
  );

  int total = 0, passed = 0, fails = 0;

  // Cumulative activity seen on the DUT outputs.
  int n_start = 0, n_stop = 0, n_rd = 0, n_oe = 0;
  logic [7:0] rxq[$];
  logic       perrq[$];

  always @(negedge clk) begin
    if (start)  n_start++;
    if (stop)   n_stop++;
    if (rd_req) n_rd++;
    if (sda_oe) n_oe++;
    if (rx_valid) begin
      rxq.push_back(rx_data);
      perrq.push_back(parity_err);
    end
  end

  logic [7:0] tx_b[8];
  logic       tx_t[8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_q(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    sda_drv = b; wait_q(H);
    scl = 1'b1;  wait_q(2*H);
    scl = 1'b0;  wait_q(H);
  endtask

  task automatic gen_start();
    if (scl == 1'b0) begin
      sda_drv = 1'b1; wait_q(H);
      scl = 1'b1;     wait_q(H);
    end
    sda_drv = 1'b0; wait_q(H);
    scl = 1'b0;     wait_q(H);
  endtask

  task automatic gen_stop();
    sda_drv = 1'b0; wait_q(H);
    scl = 1'b1;     wait_q(H);
    sda_drv = 1'b1; wait_q(H);
  endtask

  // Header bits plus the ACK slot; samples SDA drive mid-way through SCL high.
  task automatic header(input logic [6:0] a, input logic rw, output logic oe_mid);
    for (int i = 6; i >= 0; i--) send_bit(a[i]);
    send_bit(rw);
    sda_drv = 1'b1; wait_q(H);
    scl = 1'b1;     wait_q(H);
    oe_mid = sda_oe; wait_q(H);
    scl = 1'b0;     wait_q(H);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic t);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    send_bit(t);
  endtask

  function automatic logic model_ack(input logic [6:0] a, input logic rw, input logic ae);
    return ae && ((a == 7'h50) || (a == 7'h7E && rw == 1'b0));
  endfunction

  function automatic logic parity_bad(input logic [7:0] b, input logic t);
    return ($countones({b, t}) % 2) == 0;
  endfunction

  // Full frame: START, header, nb data bytes from tx_b/tx_t, STOP.
  task automatic xfer(input string tag, input logic [6:0] a, input logic rw,
                      input logic ae, input int nb);
    int bs, bst, brd, boe, bq;
    logic exp_ack, oe_mid;
    logic [7:0] exp_b[$];
    logic       exp_e[$];
    bs = n_start; bst = n_stop; brd = n_rd; boe = n_oe; bq = rxq.size();
    ack_en  = ae;
    exp_ack = model_ack(a, rw, ae);
    gen_start();
    header(a, rw, oe_mid);
    check({tag, "_ack_oe"}, oe_mid, exp_ack);
    check({tag, "_addr_match"}, addr_match, exp_ack);
    check({tag, "_busy"}, busy, 1);
    if (exp_ack) check({tag, "_rnw"}, rnw, rw);
    for (int i = 0; i < nb; i++) send_byte(tx_b[i], tx_t[i]);
    gen_stop();
    wait_q(6);
    if (exp_ack && !rw) begin
      for (int i = 0; i < nb; i++) begin
        exp_b.push_back(tx_b[i]);
        exp_e.push_back(parity_bad(tx_b[i], tx_t[i]));
        if (parity_bad(tx_b[i], tx_t[i])) break;
      end
    end
    check({tag, "_start_cnt"}, n_start - bs, 1);
    check({tag, "_stop_cnt"}, n_stop - bst, 1);
    check({tag, "_rd_req_cnt"}, n_rd - brd, (exp_ack && rw) ? 1 : 0);
    check({tag, "_oe_cycles"}, n_oe - boe, exp_ack ? 4*H : 0);
    check({tag, "_rx_cnt"}, rxq.size() - bq, exp_b.size());
    for (int i = 0; i < exp_b.size() && bq + i < rxq.size(); i++) begin
      check({tag, "_rx_data"}, rxq[bq+i], exp_b[i]);
      check({tag, "_parity_err"}, perrq[bq+i], exp_e[i]);
    end
    check({tag, "_busy_after"}, busy, 0);
    check({tag, "_match_after"}, addr_match, 0);
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int bs, bst, bq;
    logic oe_mid;
    logic [6:0] ra;
    logic rrw, rae;
    int nb;

    rst_n = 1'b0; target_en = 1'b1; ack_en = 1'b1; scl = 1'b1; sda_drv = 1'b1;
    wait_q(3);
    check("rst_sda_oe", sda_oe, 0);
    check("rst_start", start, 0);
    check("rst_busy", busy, 0);
    check("rst_match", addr_match, 0);
    check("rst_rx_valid", rx_valid, 0);
    check("rst_rx_data", rx_data, 8'h00);
    rst_n = 1'b1;
    wait_q(10);
    check("idle_no_start", n_start, 0);
    check("idle_no_stop", n_stop, 0);

    // Good write with two correct-parity bytes.
    tx_b[0] = 8'hA5; tx_t[0] = 1'b1;
    tx_b[1] = 8'h3C; tx_t[1] = 1'b1;
    xfer("wr2", 7'h50, 1'b0, 1'b1, 2);
    check("wr2_rx_data_held", rx_data, 8'h3C);

    // Wrong T-bit on the first byte; the following byte is dropped.
    tx_b[0] = 8'h01; tx_t[0] = 1'b1;
    tx_b[1] = 8'hFF; tx_t[1] = 1'b1;
    xfer("perr", 7'h50, 1'b0, 1'b1, 2);

    tx_b[0] = 8'h5A; tx_t[0] = 1'b1;
    xfer("bcast_w", 7'h7E, 1'b0, 1'b1, 1);
    xfer("bcast_r", 7'h7E, 1'b1, 1'b1, 1);
    xfer("other_w", 7'h51, 1'b0, 1'b1, 1);
    xfer("ackdis_w", 7'h50, 1'b0, 1'b0, 1);
    xfer("own_r", 7'h50, 1'b1, 1'b1, 1);

    // Repeated START after a partial byte.
    bs = n_start; bst = n_stop; bq = rxq.size();
    ack_en = 1'b1;
    gen_start();
    header(7'h50, 1'b0, oe_mid);
    check("sr_first_ack", oe_mid, 1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    gen_start();
    check("sr_start_cnt", n_start - bs, 2);
    check("sr_match_clear", addr_match, 0);
    check("sr_busy", busy, 1);
    header(7'h50, 1'b0, oe_mid);
    check("sr_second_ack", oe_mid, 1);
    check("sr_second_match", addr_match, 1);
    gen_stop();
    wait_q(6);
    check("sr_rx_cnt", rxq.size() - bq, 0);
    check("sr_stop_cnt", n_stop - bst, 1);

    // Disable mid-frame: no STOP pulse and no false START on re-enable.
    bs = n_start; bst = n_stop;
    gen_start();
    header(7'h50, 1'b0, oe_mid);
    target_en = 1'b0;
    wait_q(2);
    check("dis_busy", busy, 0);
    check("dis_match", addr_match, 0);
    gen_stop();
    target_en = 1'b1;
    wait_q(10);
    check("dis_start_cnt", n_start - bs, 1);
    check("dis_stop_cnt", n_stop - bst, 0);

    // Reset while the target is driving the ACK.
    gen_start();
    for (int i = 6; i >= 0; i--) send_bit(7'h50 >> i);
    send_bit(1'b0);
    sda_drv = 1'b1; wait_q(H);
    scl = 1'b1;     wait_q(H);
    check("rst_mid_oe_before", sda_oe, 1);
    rst_n = 1'b0;
    wait_q(1);
    check("rst_mid_oe", sda_oe, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_match", addr_match, 0);
    check("rst_mid_rx_data", rx_data, 8'h00);
    rst_n = 1'b1;
    bs = n_start; bst = n_stop;
    wait_q(20);
    check("rst_mid_no_start", n_start - bs, 0);
    check("rst_mid_no_stop", n_stop - bst, 0);

    // Randomized frames.
    for (int k = 0; k < 10; k++) begin
      case ($urandom_range(0, 3))
        0: ra = 7'h50;
        1: ra = 7'h7E;
        2: ra = 7'h51;
        default: ra = 7'($urandom_range(0, 127));
      endcase
      rrw = ($urandom_range(0, 3) == 0);
      rae = ($urandom_range(0, 4) != 0);
      nb  = $urandom_range(1, 3);
      for (int i = 0; i < nb; i++) begin
        tx_b[i] = 8'($urandom_range(0, 255));
        tx_t[i] = ($countones(tx_b[i]) % 2 == 0) ? 1'b1 : 1'b0;
        if ($urandom_range(0, 3) == 0) tx_t[i] = ~tx_t[i];
      end
      xfer("rand", ra, rrw, rae, nb);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
